// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB slave.
// Holds the FSM state encoding, the default device ID and the byte width.
package sccb_pkg;

  localparam int         BYTE_W         = 8;
  localparam int         REG_DEPTH      = 1 << BYTE_W;
  localparam logic [7:0] DEV_ID_DEFAULT = 8'h42;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ID,
    ST_ID_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_NA,
    ST_WAIT_STOP
  } state_e;

endpackage

// File: rtl/sccb_slave_sync.sv
// Bus front end for the SCCB slave: 2-FF synchronizers on SCL/SDA, SCL edge
// detectors and START/STOP detectors.
// Ports:
//   clk_25m, rst_n           system clock, async active-low reset
//   scl_in, sda_in           raw pad inputs (asynchronous)
//   scl_rise, scl_fall       combinational pulses on the synchronized SCL edge
//   sda_s                    synchronized SDA level
//   start_det, stop_det      registered pulses, one cycle after the SDA edge
module sccb_slave_sync (
  input  logic clk_25m,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d;
  logic       sda_prev_q, sda_prev_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;

  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_in};
    sda_sync_d = {sda_sync_q[0], sda_in};
    scl_prev_d = scl_sync_q[1];
    sda_prev_d = sda_sync_q[1];
    // SCL must be high on both sides of the SDA edge so that an SCL edge
    // landing in the same cycle is never mistaken for a bus condition.
    start_d = scl_sync_q[1] & scl_prev_q &  sda_prev_q & ~sda_sync_q[1];
    stop_d  = scl_sync_q[1] & scl_prev_q & ~sda_prev_q &  sda_sync_q[1];
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  assign scl_rise  =  scl_sync_q[1] & ~scl_prev_q;
  assign scl_fall  = ~scl_sync_q[1] &  scl_prev_q;
  assign sda_s     = sda_sync_q[1];
  assign start_det = start_q;
  assign stop_det  = stop_q;

endmodule

// File: rtl/sccb_slave.sv
// SCCB slave with a 256 x 8 register file.
// Accepts 3-phase writes (ID, sub-address, data) and 2-phase writes (ID,
// sub-address) that only set the sub-address. With SCCB_SLAVE_READ_EN defined,
// a read ID returns regfile[sub] MSB first; otherwise read IDs are ignored.
// Ports:
//   clk_25m, rst_n     system clock, async active-low reset
//   scl_in, sda_in     SCCB bus inputs (asynchronous)
//   sda_oe             1 pulls SDA low; the pad is open-drain
//   wr_pulse           one-cycle strobe per completed register write
//   wr_addr, wr_data   address/data of the last write
//   busy               high from START until STOP
//   err_pulse          one-cycle strobe on ID mismatch or mid-byte START/STOP
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | bus idle, waiting for START
// ST_ID        | receiving device ID byte
// ST_ID_ACK    | driving ACK for the ID byte
// ST_SUB       | receiving sub-address byte
// ST_SUB_ACK   | driving ACK for the sub-address
// ST_WDATA     | receiving write data byte
// ST_WDATA_ACK | driving ACK for the data byte
// ST_RDATA     | shifting regfile[sub] out MSB first
// ST_RDATA_NA  | master's NA bit, SDA released
// ST_WAIT_STOP | transaction done or rejected, waiting for STOP
module sccb_slave
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ID = DEV_ID_DEFAULT
) (
  input  logic              clk_25m,
  input  logic              rst_n,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              wr_pulse,
  output logic [BYTE_W-1:0] wr_addr,
  output logic [BYTE_W-1:0] wr_data,
  output logic              busy,
  output logic              err_pulse
);

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  sccb_slave_sync u_sync (
    .clk_25m   (clk_25m),
    .rst_n     (rst_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_s     (sda_s),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_e              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-2:0]   shift_q, shift_d;
  logic                bit_q, bit_d;
  logic                bit_vld_q, bit_vld_d;
  logic [BYTE_W-1:0]   sub_q, sub_d;
  logic [BYTE_W-1:0]   wr_addr_q, wr_addr_d;
  logic                sda_oe_q, sda_oe_d;
  logic                busy_q, busy_d;
  logic                wr_pulse_q, wr_pulse_d;
  logic                err_pulse_q, err_pulse_d;
  logic                mem_we;
  logic [BYTE_W-1:0]   rx_byte;
  logic [BYTE_W-1:0]   mem_q [REG_DEPTH];
`ifdef SCCB_SLAVE_READ_EN
  logic                rnw_q, rnw_d;
  logic [BYTE_W-2:0]   tx_q, tx_d;
  logic [BYTE_W-1:0]   rd_byte;

  assign rd_byte = mem_q[sub_q];
`endif

  // A bit is sampled on SCL rise but only committed on the following SCL
  // fall. The SCL rise that precedes a STOP or repeated START therefore
  // never counts as a data bit, and a START's own SCL fall is ignored.
  assign rx_byte = {shift_q, bit_q};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    bit_vld_d   = bit_vld_q;
    sub_d       = sub_q;
    wr_addr_d   = wr_addr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_pulse_d  = 1'b0;
    err_pulse_d = 1'b0;
    mem_we      = 1'b0;
`ifdef SCCB_SLAVE_READ_EN
    rnw_d       = rnw_q;
    tx_d        = tx_q;
`endif
    if (stop_det) begin
      state_d     = ST_IDLE;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      bit_cnt_d   = '0;
      bit_vld_d   = 1'b0;
      err_pulse_d = (bit_cnt_q != 3'd0);
    end else if (start_det) begin
      state_d     = ST_ID;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b1;
      bit_cnt_d   = '0;
      bit_vld_d   = 1'b0;
      err_pulse_d = (bit_cnt_q != 3'd0);
    end else if (scl_rise) begin
      bit_d     = sda_s;
      bit_vld_d = 1'b1;
    end else if (scl_fall) begin
      bit_vld_d = 1'b0;
      if (bit_vld_q) begin
        case (state_q)
          ST_ID: begin
            shift_d   = rx_byte[BYTE_W-2:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (rx_byte[7:1] != DEV_ID[7:1]) begin
                state_d     = ST_WAIT_STOP;
                err_pulse_d = 1'b1;
              end else if (rx_byte[0]) begin
`ifdef SCCB_SLAVE_READ_EN
                rnw_d    = 1'b1;
                state_d  = ST_ID_ACK;
                sda_oe_d = 1'b1;
`else
                state_d  = ST_WAIT_STOP;
`endif
              end else begin
`ifdef SCCB_SLAVE_READ_EN
                rnw_d    = 1'b0;
`endif
                state_d  = ST_ID_ACK;
                sda_oe_d = 1'b1;
              end
            end
          end
          ST_ID_ACK: begin
`ifdef SCCB_SLAVE_READ_EN
            if (rnw_q) begin
              state_d   = ST_RDATA;
              sda_oe_d  = ~rd_byte[BYTE_W-1];
              tx_d      = rd_byte[BYTE_W-2:0];
              bit_cnt_d = '0;
            end else begin
              state_d  = ST_SUB;
              sda_oe_d = 1'b0;
            end
`else
            state_d  = ST_SUB;
            sda_oe_d = 1'b0;
`endif
          end
          ST_SUB: begin
            shift_d   = rx_byte[BYTE_W-2:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              sub_d    = rx_byte;
              state_d  = ST_SUB_ACK;
              sda_oe_d = 1'b1;
            end
          end
          ST_SUB_ACK: begin
            state_d  = ST_WDATA;
            sda_oe_d = 1'b0;
          end
          ST_WDATA: begin
            shift_d   = rx_byte[BYTE_W-2:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              mem_we     = 1'b1;
              wr_addr_d  = sub_q;
              wr_pulse_d = 1'b1;
              state_d    = ST_WDATA_ACK;
              sda_oe_d   = 1'b1;
            end
          end
          ST_WDATA_ACK: begin
            state_d  = ST_WAIT_STOP;
            sda_oe_d = 1'b0;
          end
`ifdef SCCB_SLAVE_READ_EN
          ST_RDATA: begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d  = ST_RDATA_NA;
              sda_oe_d = 1'b0;
            end else begin
              sda_oe_d = ~tx_q[BYTE_W-2];
              tx_d     = {tx_q[BYTE_W-3:0], 1'b0};
            end
          end
          ST_RDATA_NA: begin
            state_d = ST_WAIT_STOP;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      bit_q       <= 1'b0;
      bit_vld_q   <= 1'b0;
      sub_q       <= '0;
      wr_addr_q   <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_pulse_q  <= 1'b0;
      err_pulse_q <= 1'b0;
`ifdef SCCB_SLAVE_READ_EN
      rnw_q       <= 1'b0;
      tx_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      bit_vld_q   <= bit_vld_d;
      sub_q       <= sub_d;
      wr_addr_q   <= wr_addr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_pulse_q  <= wr_pulse_d;
      err_pulse_q <= err_pulse_d;
`ifdef SCCB_SLAVE_READ_EN
      rnw_q       <= rnw_d;
      tx_q        <= tx_d;
`endif
    end
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[sub_q] <= rx_byte;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_pulse  = wr_pulse_q;
  assign err_pulse = err_pulse_q;
  assign wr_addr   = wr_addr_q;
  // wr_addr and the regfile entry it points at always change together, so
  // the regfile itself holds the last written data byte.
  assign wr_data   = mem_q[wr_addr_q];

endmodule

// File: tb/tb_sccb_slave.sv
// Testbench for sccb_slave: bit-banged SCCB master, behavioural register
// model and queue-based scoreboard with independent monitors.
module tb_sccb_slave;

  logic       clk_25m = 1'b0;
  logic       rst_n   = 1'b0;
  logic       scl     = 1'b1;
  logic       sda_m   = 1'b1;
  logic       sda_line;
  logic       sda_oe, wr_pulse, busy, err_pulse;
  logic [7:0] wr_addr, wr_data;

  int checks = 0;
  int errors = 0;
  int q      = 1250;    // quarter SCL period; 1250 gives 200 kHz
  int slot_kind = 0;    // 0 none, 1 master-driven bit, 2 slave-driven bit

  logic        exp_bit_q[$];
  logic [15:0] exp_wr_q[$];
  int          exp_err_q[$];
  logic [7:0]  m_mem [256];
  logic [7:0]  m_sub = 8'h00;

  always #20 clk_25m = ~clk_25m;

  assign sda_line = sda_m & ~sda_oe;

  sccb_slave dut (
    .clk_25m   (clk_25m),
    .rst_n     (rst_n),
    .scl_in    (scl),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .wr_pulse  (wr_pulse),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .err_pulse (err_pulse)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Pulse monitor: every strobe must match a queued expectation.
  always @(negedge clk_25m) begin
    if (rst_n) begin
      if (wr_pulse) begin
        chk("wr_pulse_expected", 32'(exp_wr_q.size() != 0), 32'd1);
        if (exp_wr_q.size() != 0) chk("wr_addr_data", {16'h0, wr_addr, wr_data}, {16'h0, exp_wr_q.pop_front()});
      end
      if (err_pulse) begin
        chk("err_pulse_expected", 32'(exp_err_q.size() != 0), 32'd1);
        if (exp_err_q.size() != 0) void'(exp_err_q.pop_front());
      end
    end
  end

  // Bus monitor: the master samples SDA on each SCL rise.
  always @(posedge scl) begin
    if (rst_n) begin
      if (slot_kind == 2) begin
        if (exp_bit_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL slave_bit got=%0b want=none_queued t=%0t", sda_line, $time);
        end else begin
          chk("slave_bit", 32'(sda_line), 32'(exp_bit_q.pop_front()));
        end
      end else if (slot_kind == 1) begin
        chk("oe_in_master_bit", 32'(sda_oe), 32'd0);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic do_start();
    slot_kind = 0;
    if (!scl) begin
      sda_m = 1'b1; #(q);
      scl = 1'b1;
    end
    #(q); sda_m = 1'b0;
    #(q); scl = 1'b0;
    #(q);
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic do_stop();
    slot_kind = 0;
    sda_m = 1'b0; #(q);
    scl = 1'b1; #(q);
    sda_m = 1'b1; #(2*q);
    chk("busy_after_stop", 32'(busy), 32'd0);
  endtask

  task automatic send_bit(input logic b);
    slot_kind = 1;
    sda_m = b; #(q);
    scl = 1'b1; #(2*q);
    scl = 1'b0; #(q);
  endtask

  task automatic slave_bit(input logic exp);
    exp_bit_q.push_back(exp);
    slot_kind = 2;
    sda_m = 1'b1; #(q);
    scl = 1'b1; #(2*q);
    scl = 1'b0; #(q);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic drained();
    repeat (4) @(negedge clk_25m);
    chk("queues_drained", exp_wr_q.size() + exp_err_q.size() + exp_bit_q.size(), 0);
  endtask

  task automatic txn_write(input logic [7:0] id, input logic [7:0] sub,
                           input logic [7:0] data, input bit two_phase);
    bit match;
    match = (id[7:1] == 7'h21);
    if (!match) exp_err_q.push_back(1);
    do_start();
    send_byte(id);
    if (!match) begin
      slave_bit(1'b1);
    end else begin
      slave_bit(1'b0);
      send_byte(sub);
      slave_bit(1'b0);
      m_sub = sub;
      if (!two_phase) begin
        exp_wr_q.push_back({sub, data});
        m_mem[sub] = data;
        send_byte(data);
        slave_bit(1'b0);
      end
    end
    do_stop();
    drained();
  endtask

  task automatic txn_read(input logic [7:0] sub, input bit set_sub, input bit rep);
`ifdef SCCB_SLAVE_READ_EN
    logic [7:0] b;
`endif
    if (set_sub) begin
      do_start();
      send_byte(8'h42); slave_bit(1'b0);
      send_byte(sub);   slave_bit(1'b0);
      m_sub = sub;
      if (!rep) do_stop();
    end
    do_start();
    send_byte(8'h43);
`ifdef SCCB_SLAVE_READ_EN
    b = m_mem[m_sub];
    slave_bit(1'b0);
    for (int i = 7; i >= 0; i--) slave_bit(b[i]);
`else
    slave_bit(1'b1);
    for (int i = 0; i < 8; i++) slave_bit(1'b1);
`endif
    send_bit(1'b1);
    do_stop();
    drained();
  endtask

  task automatic txn_abort(input logic [7:0] sub, input logic [3:0] bits);
    exp_err_q.push_back(1);
    do_start();
    send_byte(8'h42); slave_bit(1'b0);
    send_byte(sub);   slave_bit(1'b0);
    m_sub = sub;
    for (int i = 3; i >= 0; i--) send_bit(bits[i]);
    do_stop();
    drained();
  endtask

  task automatic txn_reset_mid(input logic [7:0] sub);
    do_start();
    send_byte(8'h42); slave_bit(1'b0);
    send_byte(sub);   slave_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    slot_kind = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_pulse", 32'(wr_pulse), 32'd0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    m_sub = 8'h00;
    exp_wr_q.delete();
    exp_err_q.delete();
    exp_bit_q.delete();
    scl = 1'b1;
    sda_m = 1'b1;
    repeat (10) @(negedge clk_25m);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_25m);
  endtask

  initial begin
    logic [7:0] r_id, r_sub, r_data;
    int kind;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    repeat (5) @(negedge clk_25m);
    chk("init_sda_oe", 32'(sda_oe), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_wr_pulse", 32'(wr_pulse), 32'd0);
    chk("init_err_pulse", 32'(err_pulse), 32'd0);
    chk("init_wr_addr", 32'(wr_addr), 32'd0);
    chk("init_wr_data", 32'(wr_data), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_25m);

    // Basic write at 200 kHz.
    txn_write(8'h42, 8'h12, 8'h80, 1'b0);
    chk("hold_wr_addr", 32'(wr_addr), 32'h12);
    chk("hold_wr_data", 32'(wr_data), 32'h80);
    q = 500;

    // Foreign device ID: rejected, nothing written.
    txn_write(8'h60, 8'h12, 8'h11, 1'b0);
    chk("hold2_wr_addr", 32'(wr_addr), 32'h12);
    chk("hold2_wr_data", 32'(wr_data), 32'h80);
    txn_read(8'h12, 1'b1, 1'b0);

    // Write, 2-phase sub-address set, then read back.
    txn_write(8'h42, 8'h3A, 8'h5C, 1'b0);
    txn_write(8'h42, 8'h3A, 8'h00, 1'b1);
    txn_read(8'h3A, 1'b0, 1'b0);

    // STOP after four data bits, then a clean write.
    txn_abort(8'h77, 4'b1010);
    txn_write(8'h42, 8'h55, 8'hA7, 1'b0);
    txn_read(8'h55, 1'b1, 1'b1);

    for (int n = 0; n < 8; n++) begin
      kind   = int'($urandom_range(0, 3));
      r_sub  = 8'($urandom);
      r_data = 8'($urandom);
      case (kind)
        0: txn_write(8'h42, r_sub, r_data, 1'b0);
        1: begin
          r_id = 8'($urandom);
          if (r_id[7:1] == 7'h21) r_id = r_id ^ 8'h80;
          txn_write(r_id, r_sub, r_data, 1'b0);
        end
        2: txn_read(r_sub, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        default: txn_abort(r_sub, 4'($urandom));
      endcase
    end

    // Reset during the data byte clears outputs and the register file.
    txn_write(8'h42, 8'hC3, 8'h9E, 1'b0);
    txn_reset_mid(8'hC3);
    txn_read(8'h00, 1'b0, 1'b0);
    txn_read(8'hC3, 1'b1, 1'b0);
    txn_write(8'h42, 8'h01, 8'h3F, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sccb_slave.md
SCCB_SLAVE -- requirements
Module: sccb_slave

Interface
REQ-001 Parameter DEV_ID, default 8'h42, 7-bit device ID in bits [7:1]; bit 0 ignored.
REQ-002 clk_25m  in  1  system clock, 25 MHz, only clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 scl_in  in  1  SCCB clock from master, asynchronous to clk_25m.
REQ-005 sda_in  in  1  SCCB data line as sensed at the pad, asynchronous.
REQ-006 sda_oe  out  1  1 = pull SDA low, 0 = release; the pad is open-drain and is never driven high.
REQ-007 wr_pulse  out  1  one-cycle strobe per completed register write.
REQ-008 wr_addr  out  8  sub-address of the last write, held until the next write.
REQ-009 wr_data  out  8  data of the last write, held until the next write.
REQ-010 busy  out  1  high from START until STOP or abort.
REQ-011 err_pulse  out  1  one-cycle strobe on an ID mismatch or on a STOP/START arriving mid-byte.

Function
REQ-012 scl_in and sda_in shall pass through a 2-FF synchronizer; all edge and condition detection shall use the synchronized values.
REQ-013 START is SDA falling while SCL is high; STOP is SDA rising while SCL is high; both are detected one cycle after the synchronized edge.
REQ-014 Data bits shall be sampled on the synchronized SCL rising edge, MSB first.
REQ-015 sda_oe shall change only on the cycle after a synchronized SCL falling edge.
REQ-016 FSM states: IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_NA, WAIT_STOP.
REQ-017 IDLE -> ID on START; START in any state shall restart at ID, a repeated start.
REQ-018 STOP in any state shall go to IDLE, release sda_oe and clear busy; if the 3-bit bit counter is nonzero, err_pulse shall fire.
REQ-019 ID: after 8 bits, if byte[7:1]==DEV_ID[7:1], go to ID_ACK; otherwise go to WAIT_STOP and fire err_pulse.
REQ-020 ID_ACK: hold sda_oe=1 for the 9th bit; next state is SUB when byte[0]=0, or RDATA when byte[0]=1.
REQ-021 SUB: latch 8 bits into the sub-address register, then SUB_ACK with sda_oe=1 for the 9th bit, then WDATA.
REQ-022 WDATA: after 8 bits, write regfile[sub], load wr_addr and wr_data, assert wr_pulse for one cycle, then WDATA_ACK, then WAIT_STOP.
REQ-023 2-phase write (ID, SUB, STOP) shall update only the sub-address register, which is retained for a later read.
REQ-024 RDATA: shift regfile[sub] out MSB first; a 0 bit gives sda_oe=1, a 1 bit gives sda_oe=0; then RDATA_NA with sda_oe=0, ignore the master's NA bit, then WAIT_STOP.
REQ-025 The register file shall be 256 x 8 with no auto-increment; sub wraps naturally as 8-bit.
REQ-026 A write and a read of the same address in one transaction are not possible; a read after a write returns the written value.

Reset
REQ-027 On rst_n low: FSM=IDLE, sda_oe=0, busy=0, wr_pulse=0, err_pulse=0, wr_addr=0, wr_data=0, sub=0, regfile all 0, synchronizers at 1.

Configuration
REQ-028 Macro SCCB_SLAVE_READ_EN: when defined, the read path of REQ-024 is present.
REQ-029 Without SCCB_SLAVE_READ_EN, an ID with bit0=1 shall go to WAIT_STOP without the ID_ACK drive, and sda_oe shall stay 0; the RDATA and RDATA_NA logic shall be absent.

Structure
REQ-030 Package sccb_pkg shall hold the state enum, the default DEV_ID constant 8'h42 and the byte-width constant.
REQ-031 Sub-module sccb_slave_sync shall hold the 2-FF synchronizer, the SCL rise/fall detectors and the START/STOP detectors.

Verification
REQ-032 Write ID 0x42, sub 0x12, data 0x80 at 200 kHz -> one wr_pulse, wr_addr=0x12, wr_data=0x80, sda_oe=1 during each 9th bit.
REQ-033 Write ID 0x60 -> no acknowledge drive, err_pulse=1, FSM idle after STOP, regfile unchanged.
REQ-034 Write 0x3A:0x5C, then 2-phase ID 0x42 / sub 0x3A / STOP, then read ID 0x43 -> SDA shows 0x5C MSB first (READ_EN build).
REQ-035 Same sequence with the macro undefined -> sda_oe stays 0 throughout the read phase.
REQ-036 STOP after 4 data bits -> err_pulse, no wr_pulse, busy=0; a following complete write succeeds.
REQ-037 Assert rst_n mid-WDATA -> sda_oe=0 immediately, all outputs at reset values, regfile cleared.
